// File: rtl/vga_renderer_pkg.sv
// Shared entity codes, standard 640x480@60 timing points and the palette.
// Pure definitions: no logic, no latency.
package vga_renderer_pkg;

  typedef enum logic [1:0] {
    ENT_NOTHING    = 2'd0,
    ENT_SNAKE_HEAD = 2'd1,
    ENT_SNAKE_TAIL = 2'd2,
    ENT_APPLE      = 2'd3
  } entity_t;

  localparam int H_ACTIVE_STD = 640;
  localparam int V_ACTIVE_STD = 480;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

  localparam logic [11:0] COLOR_BLACK   = 12'h000;
  localparam logic [11:0] COLOR_HEAD    = 12'hFF0;
  localparam logic [11:0] COLOR_TAIL    = 12'h0C0;
  localparam logic [11:0] COLOR_APPLE   = 12'hF00;
  localparam logic [11:0] COLOR_BG_OVER = 12'h400;
  localparam logic [11:0] COLOR_BG_WON  = 12'h006;

  // Sync and blank bits travelling down the alignment pipe.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  // Overlays only tint empty background; game-over has priority over game-won.
  function automatic logic [11:0] entity_color(input entity_t ent, input logic over, input logic won);
    logic [11:0] c;
    c = COLOR_BLACK;
    case (ent)
      ENT_SNAKE_HEAD: c = COLOR_HEAD;
      ENT_SNAKE_TAIL: c = COLOR_TAIL;
      ENT_APPLE:      c = COLOR_APPLE;
      default:        c = over ? COLOR_BG_OVER : (won ? COLOR_BG_WON : COLOR_BLACK);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_renderer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency 2 clocks, no backpressure.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_renderer.sv
// VGA timing, entity-to-RGB mapping with frame-latched overlays, and update clock.
// x_out to pins: ENTITY_LATENCY+1 clocks; free-running, no backpressure.
module vga_renderer
  import vga_renderer_pkg::*;
#(
  parameter int H_VISIBLE         = H_ACTIVE_STD,
  parameter int H_FRONT           = H_SYNC_START - H_ACTIVE_STD,
  parameter int H_SYNC            = H_SYNC_END - H_SYNC_START,
  parameter int H_BACK            = H_TOTAL - H_SYNC_END,
  parameter int V_VISIBLE         = V_ACTIVE_STD,
  parameter int V_FRONT           = V_SYNC_START - V_ACTIVE_STD,
  parameter int V_SYNC            = V_SYNC_END - V_SYNC_START,
  parameter int V_BACK            = V_TOTAL - V_SYNC_END,
  parameter int ENTITY_LATENCY    = 1,
  parameter int FRAMES_PER_UPDATE = 8
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [1:0] entity,
  input  logic       game_over,
  input  logic       game_won,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_tick,
  output logic       update_clk_out
);

  localparam logic [9:0] L_H_MAX    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] L_V_MAX    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] L_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] L_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] L_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] L_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] L_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] L_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] L_FRM_MAX  = 8'(FRAMES_PER_UPDATE - 1);
  localparam logic [7:0] L_FRM_HALF = 8'(FRAMES_PER_UPDATE / 2);

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        r_frame_tick;
  timing_t     w_raw;
  timing_t     w_aligned;
  timing_t [ENTITY_LATENCY-1:0] r_dly;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;
  logic        w_go_s;
  logic        w_gw_s;
  logic        r_go_lat;
  logic        r_gw_lat;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  w_frame_next;
  logic        r_update_clk;

  always_comb begin
    w_h_next = r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (r_h_cnt == L_H_MAX) begin
      w_h_next = 10'd0;
      w_v_next = (r_v_cnt == L_V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  // frame_tick is decoded from the next count so it lines up with x_out/y_out.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt      <= 10'd0;
      r_v_cnt      <= 10'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_h_cnt      <= w_h_next;
      r_v_cnt      <= w_v_next;
      r_frame_tick <= (w_h_next == 10'd0) && (w_v_next == L_V_VIS);
    end
  end

  always_comb begin
    w_raw.hs     = !((r_h_cnt >= L_HS_START) && (r_h_cnt < L_HS_END));
    w_raw.vs     = !((r_v_cnt >= L_VS_START) && (r_v_cnt < L_VS_END));
    w_raw.active = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTITY_LATENCY; i++) r_dly[i] <= TIMING_IDLE;
    end else begin
      r_dly[0] <= w_raw;
      for (int i = 1; i < ENTITY_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_aligned = r_dly[ENTITY_LATENCY-1];

  sync_2ff u_go_sync (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     (game_over),
    .o_q     (w_go_s)
  );

  sync_2ff u_gw_sync (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     (game_won),
    .o_q     (w_gw_s)
  );

  // Overlay flags only move at the start of vertical blanking, never mid-frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go_lat <= 1'b0;
      r_gw_lat <= 1'b0;
    end else if (r_frame_tick) begin
      r_go_lat <= w_go_s;
      r_gw_lat <= w_gw_s;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 12'h000;
    end else begin
      r_hsync <= w_aligned.hs;
      r_vsync <= w_aligned.vs;
      r_rgb   <= w_aligned.active ? entity_color(entity_t'(entity), r_go_lat, r_gw_lat) : 12'h000;
    end
  end

  assign w_frame_next = (r_frame_cnt == L_FRM_MAX) ? 8'd0 : r_frame_cnt + 8'd1;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt  <= 8'd0;
      r_update_clk <= 1'b0;
    end else if (r_frame_tick) begin
      r_frame_cnt  <= w_frame_next;
      r_update_clk <= (w_frame_next < L_FRM_HALF);
    end
  end

  assign x_out          = r_h_cnt;
  assign y_out          = r_v_cnt;
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign red            = r_rgb[11:8];
  assign green          = r_rgb[7:4];
  assign blue           = r_rgb[3:0];
  assign frame_tick     = r_frame_tick;
  assign update_clk_out = r_update_clk;

endmodule

// File: tb/tb_vga_renderer.sv
// Bench for vga_renderer on a shrunken 30x17 raster (510 cycles per frame).
// A cycle-indexed reference predicts every output; literal counts pin the reference.
module tb_vga_renderer;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FPU = 8;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [1:0] entity;
  logic       game_over;
  logic       game_won;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       frame_tick;
  logic       update_clk_out;

  vga_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ENTITY_LATENCY(1), .FRAMES_PER_UPDATE(FPU)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .entity(entity),
    .game_over(game_over), .game_won(game_won),
    .x_out(x_out), .y_out(y_out), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_tick(frame_tick), .update_clk_out(update_clk_out)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;

  // Reference state: cycles since reset release, ticks seen, latched flags, driven entities.
  int cyc = 0;
  int k_ticks = 0;
  logic lat_go = 1'b0;
  logic lat_gw = 1'b0;
  logic [1:0] e_cur = 2'd0;
  logic [1:0] e_last = 2'd0;
  int mode = 0;

  int win_lo = 0, win_hi = 0, uw_lo = 0, uw_hi = 0;
  int lit, lit_head, lit_over, lit_won, hs_low, vs_low, apple_n, upd_high;
  int first_fall = -1, first_tick = -1, last_tick = -1, first_rise = -1;
  int tick_cnt = 0, min_sp = 1000000, max_sp = 0;
  logic prev_hs = 1'b1;
  logic prev_upd = 1'b0;

  int n, px, py, sp;
  logic exp_hs, exp_vs;
  logic [11:0] exp_rgb, got_rgb;

  function automatic int cx(input int c);
    return c % HT;
  endfunction

  function automatic int cy(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic logic [1:0] ent_for(input int m, input int x, input int y);
    if (m == 1) return (x == 5 && y == 3) ? 2'd3 : 2'd0;
    if (m == 2) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [11:0] colour(input logic [1:0] e);
    case (e)
      2'd1: return 12'hFF0;
      2'd2: return 12'h0C0;
      2'd3: return 12'hF00;
      default: return lat_go ? 12'h400 : (lat_gw ? 12'h006 : 12'h000);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference advance and entity drive, just after each rising edge.
  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      if (!reset_n) begin
        cyc = 0; k_ticks = 0; lat_go = 1'b0; lat_gw = 1'b0; e_cur = 2'd0; e_last = 2'd0;
      end else begin
        if (cx(cyc) == 0 && cy(cyc) == VV) begin
          k_ticks++;
          lat_go = game_over;
          lat_gw = game_won;
        end
        cyc++;
        e_last = e_cur;
        e_cur = ent_for(mode, cx(cyc - 1), cy(cyc - 1));
      end
      entity = e_cur;
    end
  end

  // Per-cycle compare plus window measurements, on the falling edge.
  always @(negedge vga_clk) begin
    got_rgb = {red, green, blue};
    if (!reset_n) begin
      chk("reset_state", {x_out, y_out, hsync, vsync, got_rgb, frame_tick, update_clk_out},
          {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0});
      prev_hs = 1'b1; prev_upd = 1'b0;
      first_fall = -1; first_tick = -1; last_tick = -1; first_rise = -1;
    end else begin
      n = cyc;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
      if (n >= 2) begin
        px = cx(n - 2);
        py = cy(n - 2);
        exp_hs = !(px >= HV + HF && px < HV + HF + HS);
        exp_vs = !(py >= VV + VF && py < VV + VF + VS);
        if (px < HV && py < VV) exp_rgb = colour(e_last);
      end
      chk("timing", {x_out, y_out, hsync, vsync, frame_tick},
          {10'(cx(n)), 10'(cy(n)), exp_hs, exp_vs, (cx(n) == 0 && cy(n) == VV)});
      chk("rgb", got_rgb, exp_rgb);
      chk("update_clk", update_clk_out, (k_ticks > 0) && ((k_ticks % FPU) < FPU / 2));

      if (n >= win_lo && n < win_hi) begin
        if (got_rgb != 12'h000) lit++;
        if (got_rgb == 12'hFF0) lit_head++;
        if (got_rgb == 12'h400) lit_over++;
        if (got_rgb == 12'h006) lit_won++;
        if (got_rgb == 12'hF00) apple_n = n;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (n >= uw_lo && n < uw_hi && update_clk_out) upd_high++;
      if (prev_hs && !hsync && first_fall < 0) first_fall = n;
      prev_hs = hsync;
      if (!prev_upd && update_clk_out && first_rise < 0) first_rise = n;
      prev_upd = update_clk_out;
      if (frame_tick) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = n;
        if (last_tick >= 0) begin
          sp = n - last_tick;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
        end
        last_tick = n;
      end
    end
  end

  task automatic open_win(input int lo, input int hi);
    lit = 0; lit_head = 0; lit_over = 0; lit_won = 0; hs_low = 0; vs_low = 0; apple_n = -1;
    win_lo = lo;
    win_hi = hi;
  endtask

  task automatic run_to(input int t);
    int guard;
    guard = 0;
    while (cyc < t) begin
      @(negedge vga_clk);
      guard++;
      if (guard > 20000) begin
        failures++;
        $display("FAIL run_to timeout waiting for cyc=%0d, got cyc=%0d", t, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; game_over = 1'b0; game_won = 1'b0; entity = 2'd0; mode = 0;
    upd_high = 0;
    repeat (3) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    uw_lo = 301; uw_hi = 301 + FPU * 510;
    open_win(2, 1022);

    run_to(1020); mode = 1;
    run_to(1022);
    chk("hsync_low_2frames", hs_low, 204);
    chk("vsync_low_2frames", vs_low, 120);
    chk("blank_bg_lit", lit, 0);
    chk("hsync_first_fall", first_fall, 22);
    chk("first_frame_tick", first_tick, 300);
    open_win(1022, 1532);

    run_to(1530); mode = 2;
    run_to(1532);
    chk("apple_lit", lit, 1);
    chk("apple_cycle", apple_n, 1117);
    open_win(1532, 2042);

    run_to(2040); mode = 0;
    run_to(2042);
    chk("head_lit", lit, 160);
    chk("head_colour", lit_head, 160);
    open_win(2042, 2552);

    run_to(2190); game_over = 1'b1; game_won = 1'b1;
    run_to(2552);
    chk("over_same_frame", lit, 0);
    open_win(2552, 3062);

    run_to(2600); game_over = 1'b0;
    run_to(3062);
    chk("over_next_frame", lit_over, 160);
    chk("over_lit", lit, 160);
    open_win(3062, 3572);

    run_to(3572); game_won = 1'b0;
    chk("won_frame", lit_won, 160);

    run_to(8317);
    chk("tick_count", tick_cnt, 16);
    chk("tick_min_spacing", min_sp, 510);
    chk("tick_max_spacing", max_sp, 510);
    chk("update_first_rise", first_rise, 301);
    chk("update_high_cycles", upd_high, 2040);

    #2 reset_n = 1'b0;
    #1;
    chk("reset_immediate", {x_out, y_out, hsync, vsync, red, green, blue},
        {10'd0, 10'd0, 1'b1, 1'b1, 12'h000});
    repeat (5) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    @(negedge vga_clk);
    chk("x_after_release", {x_out, y_out}, {10'd1, 10'd0});
    run_to(400);
    chk("tick_after_reset", first_tick, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
